// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and state type for the forward and inverse NTT address units
package ntt_pkg;

    localparam int PARAM_LOG_MAX_N_HALF = 4;
    localparam int NTT_ADDR_WIDTH       = 6;
    localparam int NTT_LOG_N            = 5;
    localparam int TW_INDEX_WIDTH       = PARAM_LOG_MAX_N_HALF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONF  = 3'd1,
        RND   = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } ntt_addr_state_t;

endpackage

// File: rtl/ntt_we_decoder.sv
// rtl/ntt_we_decoder.sv - one-hot-pair RAM write-enable decoder shared by the NTT address units
module ntt_we_decoder
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH = NTT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]    waddr1,
    input  logic [ADDR_WIDTH-1:0]    waddr2,
    input  logic                     en,
    output logic [2**ADDR_WIDTH-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[waddr1] = 1'b1;
            we[waddr2] = 1'b1;
        end
    end

endmodule

// File: rtl/intt_address_unit.sv
// rtl/intt_address_unit.sv - inverse NTT (Gentleman-Sande) address generator with a final n^-1 scaling pass
module intt_address_unit
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH = NTT_ADDR_WIDTH,
    parameter int LOG_N      = NTT_LOG_N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      intt_start,
    input  logic                      single_bf,
    output logic [TW_INDEX_WIDTH-1:0] index,
    output logic                      update_m,
    output logic                      update_omega,
    output logic                      run_loop_o,
    output logic                      scale_o,
    output logic                      done_o,
    output logic [ADDR_WIDTH-1:0]     raddr1_o,
    output logic [ADDR_WIDTH-1:0]     raddr2_o,
    output logic [ADDR_WIDTH-1:0]     waddr1_o,
    output logic [ADDR_WIDTH-1:0]     waddr2_o,
    output logic [2**ADDR_WIDTH-1:0]  we_o
);

    localparam int               N      = 1 << LOG_N;
    localparam logic [LOG_N:0]   M_FULL = (LOG_N+1)'(N);
    localparam logic [LOG_N:0]   M_LAST = (LOG_N+1)'(2);
    localparam logic [LOG_N:0]   M_ONE  = (LOG_N+1)'(1);
    localparam logic [LOG_N-1:0] K_LAST = LOG_N'(N - 2);
    localparam logic [LOG_N-1:0] S_LAST = LOG_N'(N / 2 - 1);

    ntt_addr_state_t state, state_nxt;

    logic [LOG_N:0]            m, m_nxt;
    logic [LOG_N-1:0]          j, j_nxt;
    logic [LOG_N-1:0]          k, k_nxt;
    logic [LOG_N-1:0]          s, s_nxt;
    logic [TW_INDEX_WIDTH-1:0] index_nxt;
    logic                      update_m_nxt;
    logic                      update_omega_nxt;

    logic                      last_bf;
    logic                      k_more;
    logic                      j_more;
    logic [LOG_N:0]            k_step;

    logic [LOG_N:0]            m_reg;
    logic [LOG_N-1:0]          j_reg;
    logic [LOG_N-1:0]          k_reg;
    logic [LOG_N-1:0]          s_reg;
    logic                      scale_reg;
    logic                      run_reg;
    logic                      done_reg;

    logic [ADDR_WIDTH-1:0]     addr1;
    logic [ADDR_WIDTH-1:0]     addr2;
    logic                      wr_en;

    assign last_bf = (m == M_LAST) && (j == '0) && (k == K_LAST);
    assign k_step  = {1'b0, k} + m;
    assign k_more  = {1'b0, k} < (M_FULL - m);
    assign j_more  = {1'b0, j} < ((m >> 1) - M_ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (intt_start) state_nxt = CONF;
            CONF:    state_nxt = RND;
            RND:     if (last_bf) state_nxt = SCALE;
            SCALE:   if (s == S_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter and twiddle-strobe updates; the stage setup is loaded on entry so CONF already presents it.
    always_comb begin
        m_nxt            = m;
        j_nxt            = j;
        k_nxt            = k;
        s_nxt            = s;
        index_nxt        = index;
        update_m_nxt     = 1'b0;
        update_omega_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (intt_start) begin
                    m_nxt        = M_FULL;
                    j_nxt        = '0;
                    k_nxt        = '0;
                    index_nxt    = '0;
                    update_m_nxt = 1'b1;
                end
            end
            RND: begin
                if (!last_bf) begin
                    if (k_more) begin
                        k_nxt = k_step[LOG_N-1:0];
                    end else begin
                        k_nxt            = '0;
                        update_omega_nxt = 1'b1;
                        if (j_more) begin
                            j_nxt = j + LOG_N'(1);
                        end else begin
                            j_nxt        = '0;
                            m_nxt        = m >> 1;
                            index_nxt    = index + TW_INDEX_WIDTH'(1);
                            update_m_nxt = 1'b1;
                        end
                    end
                end
            end
            SCALE: begin
                s_nxt = (s == S_LAST) ? '0 : s + LOG_N'(1);
            end
            DONE: begin
                m_nxt     = M_FULL;
                j_nxt     = '0;
                k_nxt     = '0;
                index_nxt = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m            <= M_FULL;
            j            <= '0;
            k            <= '0;
            s            <= '0;
            index        <= '0;
            update_m     <= 1'b0;
            update_omega <= 1'b0;
        end else begin
            m            <= m_nxt;
            j            <= j_nxt;
            k            <= k_nxt;
            s            <= s_nxt;
            index        <= index_nxt;
            update_m     <= update_m_nxt;
            update_omega <= update_omega_nxt;
        end
    end

    // One-cycle delay lines match the twiddle ROM latency behind update_m/update_omega.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            s_reg     <= '0;
            scale_reg <= 1'b0;
            run_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            m_reg     <= m;
            j_reg     <= j;
            k_reg     <= k;
            s_reg     <= s;
            scale_reg <= (state == SCALE);
            run_reg   <= (state == RND) || (state == SCALE);
            done_reg  <= (state == DONE);
        end
    end

    always_comb begin
        if (scale_reg) begin
            addr1 = ADDR_WIDTH'({s_reg, 1'b0});
            addr2 = ADDR_WIDTH'({s_reg, 1'b1});
        end else begin
            addr1 = ADDR_WIDTH'(k_reg) + ADDR_WIDTH'(j_reg);
            addr2 = addr1 + ADDR_WIDTH'(m_reg >> 1);
        end
    end

    assign wr_en      = run_reg | single_bf;
    assign raddr1_o   = addr1;
    assign raddr2_o   = addr2;
    assign waddr1_o   = wr_en ? addr1 : '0;
    assign waddr2_o   = wr_en ? addr2 : ADDR_WIDTH'(1);
    assign run_loop_o = run_reg;
    assign scale_o    = scale_reg;
    assign done_o     = done_reg;

    ntt_we_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_we_decoder (
        .waddr1 (waddr1_o),
        .waddr2 (waddr2_o),
        .en     (wr_en),
        .we     (we_o)
    );

endmodule

// File: tb/tb_intt_address_unit.sv
// tb/tb_intt_address_unit.sv - self-checking bench for intt_address_unit against an op-list reference model
module tb_intt_address_unit;

    localparam int AW   = 6;
    localparam int LN   = 5;
    localparam int NN   = 1 << LN;
    localparam int NBF  = LN * NN / 2;
    localparam int NOPS = NBF + NN / 2;
    localparam int RUNC = NOPS + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            intt_start = 1'b0;
    logic            single_bf = 1'b0;
    logic [3:0]      index;
    logic            update_m;
    logic            update_omega;
    logic            run_loop_o;
    logic            scale_o;
    logic            done_o;
    logic [AW-1:0]   raddr1_o;
    logic [AW-1:0]   raddr2_o;
    logic [AW-1:0]   waddr1_o;
    logic [AW-1:0]   waddr2_o;
    logic [63:0]     we_o;

    intt_address_unit #(
        .ADDR_WIDTH (AW),
        .LOG_N      (LN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .intt_start   (intt_start),
        .single_bf    (single_bf),
        .index        (index),
        .update_m     (update_m),
        .update_omega (update_omega),
        .run_loop_o   (run_loop_o),
        .scale_o      (scale_o),
        .done_o       (done_o),
        .raddr1_o     (raddr1_o),
        .raddr2_o     (raddr2_o),
        .waddr1_o     (waddr1_o),
        .waddr2_o     (waddr2_o),
        .we_o         (we_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_a1[NOPS];
    int exp_a2[NOPS];
    int exp_stage[NOPS];
    bit exp_sc[NOPS];
    bit exp_um[NOPS];
    bit exp_uo[NOPS];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pair_mask(input int a, input int b);
        logic [63:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        return v;
    endfunction

    // Operation list straight from the loop nest: stages m=N..2, j outer, k inner, then the scale pairs.
    task automatic build_model();
        int i;
        int m;
        i = 0;
        for (int st = 0; st < LN; st++) begin
            m = NN >> st;
            for (int jj = 0; jj < m / 2; jj++) begin
                for (int kk = 0; kk < NN; kk += m) begin
                    exp_a1[i]    = kk + jj;
                    exp_a2[i]    = kk + jj + m / 2;
                    exp_stage[i] = st;
                    exp_sc[i]    = 1'b0;
                    exp_um[i]    = (st > 0) && (jj == 0) && (kk == 0);
                    exp_uo[i]    = (i > 0) && (kk == 0);
                    i++;
                end
            end
        end
        for (int ss = 0; ss < NN / 2; ss++) begin
            exp_a1[i]    = 2 * ss;
            exp_a2[i]    = 2 * ss + 1;
            exp_stage[i] = 0;
            exp_sc[i]    = 1'b1;
            exp_um[i]    = 1'b0;
            exp_uo[i]    = 1'b0;
            i++;
        end
    endtask

    task automatic check_idle(input string tag, input bit chk_index);
        check_eq({tag, ".run"}, run_loop_o, 0);
        check_eq({tag, ".scale"}, scale_o, 0);
        check_eq({tag, ".done"}, done_o, 0);
        check_eq({tag, ".upd_m"}, update_m, 0);
        check_eq({tag, ".upd_om"}, update_omega, 0);
        check_eq({tag, ".waddr1"}, waddr1_o, 0);
        check_eq({tag, ".waddr2"}, waddr2_o, 1);
        check_eq({tag, ".we"}, we_o, 0);
        if (chk_index) check_eq({tag, ".index"}, index, 0);
    endtask

    // Entered one cycle after intt_start was driven; the first negedge is the CONF cycle t.
    task automatic do_run(input bit start_next, input int abort_at);
        int  wcount[NN];
        int  cnt_um;
        int  cnt_uo;
        int  cnt_run;
        int  cnt_done;
        bit  aborted;
        bit  in_op;
        int  op;
        aborted = 1'b0;
        for (int w = 0; w < NN; w++) wcount[w] = 0;
        @(negedge clk);
        check_eq("conf.upd_m", update_m, 1);
        check_eq("conf.upd_om", update_omega, 0);
        check_eq("conf.index", index, 0);
        check_eq("conf.run", run_loop_o, 0);
        cnt_um   = 1;
        cnt_uo   = 0;
        cnt_run  = 0;
        cnt_done = 0;
        intt_start = 1'($urandom_range(0, 1));
        for (int d = 1; d <= RUNC; d++) begin
            @(negedge clk);
            in_op = (d >= 2) && (d <= NOPS + 1);
            op    = d - 2;
            check_eq($sformatf("run.d%0d", d), run_loop_o, in_op);
            check_eq($sformatf("scale.d%0d", d), scale_o, in_op && exp_sc[op]);
            check_eq($sformatf("done.d%0d", d), done_o, d == RUNC);
            if (in_op) begin
                check_eq($sformatf("raddr1.d%0d", d), raddr1_o, exp_a1[op]);
                check_eq($sformatf("raddr2.d%0d", d), raddr2_o, exp_a2[op]);
                check_eq($sformatf("waddr1.d%0d", d), waddr1_o, exp_a1[op]);
                check_eq($sformatf("waddr2.d%0d", d), waddr2_o, exp_a2[op]);
                check_eq($sformatf("we.d%0d", d), we_o, pair_mask(exp_a1[op], exp_a2[op]));
            end else begin
                check_eq($sformatf("waddr1_idle.d%0d", d), waddr1_o, 0);
                check_eq($sformatf("waddr2_idle.d%0d", d), waddr2_o, 1);
                check_eq($sformatf("we_idle.d%0d", d), we_o, 0);
            end
            if (d <= NBF) begin
                check_eq($sformatf("index.d%0d", d), index, exp_stage[d-1]);
                check_eq($sformatf("upd_m.d%0d", d), update_m, exp_um[d-1]);
                check_eq($sformatf("upd_om.d%0d", d), update_omega, exp_uo[d-1]);
            end else begin
                check_eq($sformatf("upd_m_tail.d%0d", d), update_m, 0);
                check_eq($sformatf("upd_om_tail.d%0d", d), update_omega, 0);
            end
            for (int w = 0; w < NN; w++) if (we_o[w]) wcount[w]++;
            cnt_um   += int'(update_m);
            cnt_uo   += int'(update_omega);
            cnt_run  += int'(run_loop_o);
            cnt_done += int'(done_o);
            if (d == abort_at) begin
                rst_n      = 1'b0;
                intt_start = 1'b0;
                aborted    = 1'b1;
                break;
            end
            intt_start = (d < RUNC) ? 1'($urandom_range(0, 1)) : start_next;
        end
        if (!aborted) begin
            check_eq("count.upd_m", cnt_um, LN);
            check_eq("count.upd_om", cnt_uo, 30);
            check_eq("count.run", cnt_run, NOPS);
            check_eq("count.done", cnt_done, 1);
            for (int w = 0; w < NN; w++)
                check_eq($sformatf("wcount[%0d]", w), wcount[w], LN + 1);
        end
    endtask

    initial begin
        int gap;
        int seen_done;
        int seen_run;
        bit b2b;

        build_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_idle($sformatf("reset_idle%0d", c), 1'b1);
        end

        intt_start = 1'b1;
        do_run(1'b1, 0);
        do_run(1'b0, 0);

        for (int r = 0; r < 3; r++) begin
            gap = $urandom_range(1, 8);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle($sformatf("gap%0d_%0d", r, g), 1'b0);
            end
            intt_start = 1'b1;
            b2b = 1'($urandom_range(0, 1));
            do_run(b2b, 0);
            if (b2b) do_run(1'b0, 0);
        end

        @(negedge clk);
        intt_start = 1'b1;
        do_run(1'b0, $urandom_range(20, 90));
        @(negedge clk);
        check_idle("after_rst", 1'b1);
        check_eq("after_rst.raddr1", raddr1_o, 0);
        check_eq("after_rst.raddr2", raddr2_o, 0);
        rst_n     = 1'b1;
        seen_done = 0;
        seen_run  = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            seen_done += int'(done_o);
            seen_run  += int'(run_loop_o);
        end
        check_eq("after_rst.no_done", seen_done, 0);
        check_eq("after_rst.no_run", seen_run, 0);

        single_bf = 1'b1;
        @(negedge clk);
        check_eq("single_bf.waddr1", waddr1_o, 0);
        check_eq("single_bf.waddr2", waddr2_o, NN / 2);
        check_eq("single_bf.we", we_o, pair_mask(0, NN / 2));
        single_bf = 1'b0;
        @(negedge clk);
        check_eq("single_bf_off.we", we_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
